// File: rtl/bcd_pkg.sv
// Shared definitions for the front-panel BCD entry buffer and the decoder path behind it.
package bcd_pkg;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ENTRY = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   localparam logic [3:0] BCD_MAX = 4'd9;
   localparam int         NIB     = 4;

endpackage

// File: rtl/bcd_digit_entry.sv
// Operator digit-entry buffer: shifts BCD digits in MSD first, supports backspace/clear,
// and holds the committed packed-BCD word until the consumer takes it.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   S_EMPTY | no digits held, digit_cnt == 0
//   S_ENTRY | 1..NDIG digits held, still editable
//   S_HOLD  | word committed, out_valid high until accepted
module bcd_digit_entry
   import bcd_pkg::*;
#(
   parameter  int NDIG = 4,
   localparam int CW   = $clog2(NDIG + 1),
   localparam int W    = NIB * NDIG
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          digit_valid,
   input  logic [3:0]    digit,
   output logic          digit_ready,
   input  logic          bksp,
   input  logic          clr,
   input  logic          enter,
   output logic [W-1:0]  data_bcd,
   output logic [CW-1:0] digit_cnt,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          err,
   output logic          ovf
);

   state_t          state;
   logic [W+3:0]    shifted_in;

   // Concatenate then truncate so NDIG == 1 needs no special-case slice.
   assign shifted_in  = {data_bcd, digit};
   assign digit_ready = (state != S_HOLD);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_EMPTY;
         data_bcd  <= '0;
         digit_cnt <= '0;
         out_valid <= 1'b0;
         err       <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         err <= 1'b0;
         ovf <= 1'b0;
         if (clr) begin
            state     <= S_EMPTY;
            data_bcd  <= '0;
            digit_cnt <= '0;
            out_valid <= 1'b0;
         end else begin
            case (state)
               S_HOLD: begin
                  if (out_ready) begin
                     state     <= S_EMPTY;
                     data_bcd  <= '0;
                     digit_cnt <= '0;
                     out_valid <= 1'b0;
                  end
               end
               default: begin
                  // Only the highest-priority event is considered, even if it is then ignored.
                  if (enter) begin
                     if (state == S_ENTRY) begin
                        state     <= S_HOLD;
                        out_valid <= 1'b1;
                     end
                  end else if (bksp) begin
                     if (state == S_ENTRY) begin
                        data_bcd  <= data_bcd >> NIB;
                        digit_cnt <= digit_cnt - CW'(1);
                        if (digit_cnt == CW'(1)) state <= S_EMPTY;
                     end
                  end else if (digit_valid) begin
                     if (digit > BCD_MAX) begin
                        err <= 1'b1;
                     end else if (digit_cnt == CW'(NDIG)) begin
                        ovf <= 1'b1;
                     end else begin
                        data_bcd  <= shifted_in[W-1:0];
                        digit_cnt <= digit_cnt + CW'(1);
                        state     <= S_ENTRY;
                     end
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bcd_digit_entry.sv
// Randomised and directed bench for bcd_digit_entry against a queue-based entry model.
module tb_bcd_digit_entry;

   localparam int NDIG = 4;
   localparam int CW   = $clog2(NDIG + 1);
   localparam int W    = 4 * NDIG;
   localparam int VW   = W + CW + 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          digit_valid = 1'b0;
   logic [3:0]    digit = 4'd0;
   logic          bksp = 1'b0;
   logic          clr = 1'b0;
   logic          enter = 1'b0;
   logic          out_ready = 1'b0;
   logic          digit_ready;
   logic [W-1:0]  data_bcd;
   logic [CW-1:0] digit_cnt;
   logic          out_valid;
   logic          err;
   logic          ovf;

   bcd_digit_entry #(.NDIG(NDIG)) dut (
      .clk(clk), .rst_n(rst_n), .digit_valid(digit_valid), .digit(digit),
      .digit_ready(digit_ready), .bksp(bksp), .clr(clr), .enter(enter),
      .data_bcd(data_bcd), .digit_cnt(digit_cnt), .out_valid(out_valid),
      .out_ready(out_ready), .err(err), .ovf(ovf)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   int q[$];
   bit held = 1'b0;
   bit m_err = 1'b0;
   bit m_ovf = 1'b0;

   function automatic void model_step(input bit dv, input int d, input bit bk,
                                      input bit cl, input bit en, input bit ordy);
      m_err = 1'b0;
      m_ovf = 1'b0;
      if (cl) begin
         q.delete();
         held = 1'b0;
      end else if (held) begin
         if (ordy) begin
            q.delete();
            held = 1'b0;
         end
      end else if (en) begin
         if (q.size() > 0) held = 1'b1;
      end else if (bk) begin
         if (q.size() > 0) void'(q.pop_back());
      end else if (dv) begin
         if (d > 9) m_err = 1'b1;
         else if (q.size() == NDIG) m_ovf = 1'b1;
         else q.push_back(d);
      end
   endfunction

   function automatic logic [W-1:0] exp_data();
      logic [W-1:0] v = '0;
      foreach (q[i]) v = (v << 4) | W'(q[i]);
      return v;
   endfunction

   function automatic logic [VW-1:0] expv();
      return {exp_data(), CW'(q.size()), held, m_err, m_ovf, ~held};
   endfunction

   function automatic logic [VW-1:0] actv();
      return {data_bcd, digit_cnt, out_valid, err, ovf, digit_ready};
   endfunction

   task automatic step(input bit dv, input logic [3:0] d, input bit bk,
                       input bit cl, input bit en, input bit ordy);
      @(negedge clk);
      digit_valid = dv; digit = d; bksp = bk; clr = cl; enter = en; out_ready = ordy;
      model_step(dv, int'(d), bk, cl, en, ordy);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input bit ordy);
      step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, ordy);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      vectors++;
      if (actv() !== {{W{1'b0}}, {CW{1'b0}}, 4'b0001}) begin
         miscompares++;
         $display("FAIL reset act=%h exp=%h", actv(), {{W{1'b0}}, {CW{1'b0}}, 4'b0001});
      end
      @(negedge clk);
      rst_n = 1'b1;
      q.delete(); held = 1'b0; m_err = 1'b0; m_ovf = 1'b0;
   endtask

   task automatic test_fill_overflow();
      for (int i = 1; i <= 4; i++) step(1'b1, 4'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (data_bcd !== 16'h1234 || digit_cnt !== 3'd4 || out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL fill data=%h cnt=%0d valid=%b exp 1234/4/0", data_bcd, digit_cnt, out_valid);
      end
      step(1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (ovf !== 1'b1 || data_bcd !== 16'h1234) begin
         miscompares++;
         $display("FAIL ovf_pulse ovf=%b data=%h exp 1/1234", ovf, data_bcd);
      end
      idle(1'b0);
      vectors++;
      if (ovf !== 1'b0 || actv() !== expv()) begin
         miscompares++;
         $display("FAIL ovf_clear act=%h exp=%h", actv(), expv());
      end
      step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_bksp_hold();
      step(1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      vectors++;
      if (data_bcd !== 16'h0007 || out_valid !== 1'b1 || digit_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL commit data=%h valid=%b ready=%b exp 0007/1/0", data_bcd, out_valid, digit_ready);
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0);
         vectors++;
         if (data_bcd !== 16'h0007 || digit_cnt !== 3'd1 || out_valid !== 1'b1 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_%0d data=%h cnt=%0d valid=%b err=%b", i, data_bcd, digit_cnt, out_valid, err);
         end
      end
      idle(1'b1);
      vectors++;
      if (out_valid !== 1'b0 || digit_cnt !== 3'd0 || data_bcd !== 16'h0) begin
         miscompares++;
         $display("FAIL accept valid=%b cnt=%0d data=%h exp 0/0/0", out_valid, digit_cnt, data_bcd);
      end
      step(1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (data_bcd !== 16'h0006 || digit_cnt !== 3'd1) begin
         miscompares++;
         $display("FAIL resume data=%h cnt=%0d exp 0006/1", data_bcd, digit_cnt);
      end
      step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_err_empty_enter();
      step(1'b1, 4'hA, 1'b0, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (err !== 1'b1 || data_bcd !== 16'h0 || digit_cnt !== 3'd0) begin
         miscompares++;
         $display("FAIL err_pulse err=%b data=%h cnt=%0d exp 1/0/0", err, data_bcd, digit_cnt);
      end
      step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      vectors++;
      if (err !== 1'b0 || out_valid !== 1'b0 || digit_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL empty_enter err=%b valid=%b ready=%b exp 0/0/1", err, out_valid, digit_ready);
      end
   endtask

   task automatic test_priority();
      step(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 4'd5, 1'b0, 1'b1, 1'b1, 1'b0);
      vectors++;
      if (data_bcd !== 16'h0 || digit_cnt !== 3'd0 || out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL clr_priority data=%h cnt=%0d valid=%b exp 0/0/0", data_bcd, digit_cnt, out_valid);
      end
      step(1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      vectors++;
      if (out_valid !== 1'b0 || data_bcd !== 16'h0 || digit_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL hold_clr valid=%b data=%h ready=%b exp 0/0/1", out_valid, data_bcd, digit_ready);
      end
   endtask

   task automatic test_decode_and_reset();
      int bin;
      for (int i = 0; i < 4; i++) step(1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      bin = 0;
      for (int i = NDIG - 1; i >= 0; i--) bin = bin * 10 + int'(data_bcd[4*i +: 4]);
      vectors++;
      if (out_valid !== 1'b1 || bin != 9999) begin
         miscompares++;
         $display("FAIL decode valid=%b bin=%0d exp 1/9999", out_valid, bin);
      end
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      vectors++;
      if (actv() !== {{W{1'b0}}, {CW{1'b0}}, 4'b0001}) begin
         miscompares++;
         $display("FAIL async_reset act=%h exp=%h", actv(), {{W{1'b0}}, {CW{1'b0}}, 4'b0001});
      end
      @(negedge clk);
      rst_n = 1'b1;
      q.delete(); held = 1'b0; m_err = 1'b0; m_ovf = 1'b0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 1) == 1, 4'($urandom_range(0, 11)),
              $urandom_range(0, 5) == 0, $urandom_range(0, 19) == 0,
              $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0);
         vectors++;
         if (actv() !== expv()) begin
            miscompares++;
            $display("FAIL random_%0d act=%h exp=%h", i, actv(), expv());
         end
      end
   endtask

   initial begin
      test_reset();
      test_fill_overflow();
      test_bksp_hold();
      test_err_empty_enter();
      test_priority();
      test_decode_and_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
